bus_slave: RTL and testbench

Serial bus responder (slave port) for the shared single-wire bus driven by the `master` block. It deserialises the 16-bit address frame and the write data, performs the access on a local memory-style interface, and serialises read data back to the master. It acknowledges each phase with `B_ACK`, and it sits between the arbiter's slave-select output and a local register file or RAM.

---
 rtl/bus_slave.sv | 173 +++++++++++++++++
 tb/tb_bus_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave.sv
// Serial bus slave: deserialises address/write data from the single-wire bus,
// drives a local memory port and serialises read data back, LSB first.
module bus_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  B_SEL,
  input  logic                  B_UTIL,
  input  logic                  B_BUS_IN,
  input  logic                  B_RW,
  output logic                  B_READY,
  output logic                  B_ACK,
  output logic                  B_BUS_OUT,
  output logic                  B_RVALID,
  output logic [ADDR_WIDTH-1:0] S_ADDR,
  output logic [7:0]            S_WDATA,
  output logic                  S_WEN,
  output logic                  S_REN,
  input  logic [7:0]            S_RDATA,
  input  logic                  S_RVALID
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, WDATA, WSTB,
    ACK_W, FETCH, ACK_R, RDATA
  } state_t;

  state_t                state, state_d;
  logic [3:0]            cnt, cnt_d;
  logic [TW-1:0]         tmo, tmo_d;
  logic [15:0]           sh, sh_d;
  logic                  ready_d, ack_d;
  logic                  bout_d, rvalid_d;
  logic                  wen_d, ren_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [7:0]            wdata_d;
  logic                  smp, expired;

  assign smp     = B_SEL & B_UTIL;
  assign expired = (tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      tmo       <= '0;
      sh        <= '0;
      B_READY   <= 1'b0;
      B_ACK     <= 1'b0;
      B_BUS_OUT <= 1'b0;
      B_RVALID  <= 1'b0;
      S_ADDR    <= '0;
      S_WDATA   <= '0;
      S_WEN     <= 1'b0;
      S_REN     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      tmo       <= tmo_d;
      sh        <= sh_d;
      B_READY   <= ready_d;
      B_ACK     <= ack_d;
      B_BUS_OUT <= bout_d;
      B_RVALID  <= rvalid_d;
      S_ADDR    <= addr_d;
      S_WDATA   <= wdata_d;
      S_WEN     <= wen_d;
      S_REN     <= ren_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    tmo_d    = tmo;
    sh_d     = sh;
    bout_d   = 1'b0;
    rvalid_d = 1'b0;
    wen_d    = 1'b0;
    ren_d    = 1'b0;
    addr_d   = S_ADDR;
    wdata_d  = S_WDATA;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        tmo_d = '0;
        if (smp) begin
          sh_d    = {B_BUS_IN, sh[15:1]};
          cnt_d   = 4'd1;
          state_d = ADDR;
        end
      end
      ADDR, WDATA: begin
        if (!B_SEL) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
        end else if (B_UTIL) begin
          sh_d  = {B_BUS_IN, sh[15:1]};
          cnt_d = cnt + 4'd1;
          tmo_d = '0;
          if (state == ADDR && cnt == 4'd15) begin
            addr_d  = sh_d[ADDR_WIDTH+1:2];
            cnt_d   = '0;
            ren_d   = ~B_RW;
            state_d = B_RW ? ACK_A : FETCH;
          end else if (state == WDATA && cnt == 4'd7) begin
            wdata_d = sh_d[15:8];
            wen_d   = 1'b1;
            cnt_d   = '0;
            state_d = WSTB;
          end
        end else if (expired) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo + 1'b1;
        end
      end
      ACK_A: state_d = WDATA;
      WSTB:  state_d = ACK_W;
      ACK_W: state_d = IDLE;
      FETCH: begin
        // S_REN still high marks the request cycle; data cannot be back yet
        if (!B_SEL) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else if (S_RVALID && !S_REN) begin
          sh_d    = {8'h00, S_RDATA};
          tmo_d   = '0;
          state_d = ACK_R;
        end else if (expired) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo + 1'b1;
        end
      end
      ACK_R: begin
        bout_d   = sh[0];
        rvalid_d = 1'b1;
        sh_d     = {1'b0, sh[15:1]};
        cnt_d    = 4'd1;
        state_d  = RDATA;
      end
      RDATA: begin
        if (cnt == 4'd8) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          bout_d   = sh[0];
          rvalid_d = 1'b1;
          sh_d     = {1'b0, sh[15:1]};
          cnt_d    = cnt + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tmo_d   = '0;
      end
    endcase
    ready_d = (state_d == IDLE) || (state_d == ADDR);
    ack_d   = (state_d == ACK_A) || (state_d == ACK_W)
           || (state_d == ACK_R);
  end

endmodule

// File: tb/tb_bus_slave.sv
// Scoreboard bench for bus_slave: random serial transactions, expected
// local strobes, acks and read bits queued by a transaction-level model.
module tb_bus_slave;

  localparam int AW = 12;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          B_SEL, B_UTIL, B_BUS_IN, B_RW;
  logic          B_READY, B_ACK, B_BUS_OUT, B_RVALID;
  logic [AW-1:0] S_ADDR;
  logic [7:0]    S_WDATA;
  logic          S_WEN, S_REN;
  logic [7:0]    S_RDATA;
  logic          S_RVALID;

  int vec  = 0;
  int miss = 0;

  logic [AW+7:0] wen_q[$];
  logic [AW-1:0] ren_q[$];
  int            ack_q[$];
  logic          bit_q[$];

  int         resp_lat = 0;
  logic [7:0] resp_data = 8'h00;

  bus_slave #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .B_SEL(B_SEL), .B_UTIL(B_UTIL),
    .B_BUS_IN(B_BUS_IN), .B_RW(B_RW), .B_READY(B_READY),
    .B_ACK(B_ACK), .B_BUS_OUT(B_BUS_OUT), .B_RVALID(B_RVALID),
    .S_ADDR(S_ADDR), .S_WDATA(S_WDATA), .S_WEN(S_WEN),
    .S_REN(S_REN), .S_RDATA(S_RDATA), .S_RVALID(S_RVALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Local memory responder: returns resp_data resp_lat cycles after S_REN.
  initial begin
    S_RVALID = 1'b0;
    S_RDATA  = 8'h00;
    forever begin
      @(negedge CLK);
      if (S_REN === 1'b1 && resp_lat >= 1) begin
        repeat (resp_lat) @(posedge CLK);
        #1;
        S_RVALID = 1'b1;
        S_RDATA  = resp_data;
        @(posedge CLK);
        #1;
        S_RVALID = 1'b0;
        S_RDATA  = 8'($urandom);
      end
    end
  end

  // Monitor: every DUT-presented event must match the head of its queue.
  initial begin
    forever begin
      @(negedge CLK);
      if (S_WEN === 1'b1) begin
        chk("wen_expected", 32'(wen_q.size() > 0), 32'd1);
        if (wen_q.size() > 0)
          chk("wen_addr_data", 32'({S_ADDR, S_WDATA}),
              32'(wen_q.pop_front()));
      end
      if (S_REN === 1'b1) begin
        chk("ren_expected", 32'(ren_q.size() > 0), 32'd1);
        if (ren_q.size() > 0)
          chk("ren_addr", 32'(S_ADDR), 32'(ren_q.pop_front()));
      end
      if (B_ACK === 1'b1) begin
        chk("ack_expected", 32'(ack_q.size() > 0), 32'd1);
        if (ack_q.size() > 0) void'(ack_q.pop_front());
      end
      if (B_RVALID === 1'b1) begin
        chk("rbit_expected", 32'(bit_q.size() > 0), 32'd1);
        if (bit_q.size() > 0)
          chk("rbit_value", 32'(B_BUS_OUT), 32'(bit_q.pop_front()));
      end
    end
  end

  task automatic do_txn(input logic [15:0] frame, input logic rw,
                        input logic [7:0] wd, input logic [7:0] rd,
                        input int lat, input int gap, input int gap_at,
                        input int drop_at);
    bit            abort_a, abort_d, tout, stop;
    int            nb, n;
    logic [AW-1:0] ea;
    ea      = AW'(frame >> 2);
    abort_a = (drop_at >= 0) || (gap >= TO && gap_at < 16);
    abort_d = !abort_a && rw && gap >= TO;
    tout    = !abort_a && !rw && lat < 1;
    if (!abort_a) begin
      if (rw) begin
        ack_q.push_back(1);
        if (!abort_d) begin
          wen_q.push_back({ea, wd});
          ack_q.push_back(2);
        end
      end else begin
        ren_q.push_back(ea);
        if (!tout) begin
          ack_q.push_back(3);
          for (int i = 0; i < 8; i++) bit_q.push_back(rd[i]);
        end
      end
    end
    resp_lat  = lat;
    resp_data = rd;
    B_RW      = rw;
    stop      = 1'b0;
    nb        = rw ? 24 : 16;
    for (int i = 0; i < nb && !stop; i++) begin
      if (i == 16) begin
        B_UTIL = 1'b0;
        tick();
      end
      if (i == drop_at) begin
        B_SEL    = 1'b0;
        B_UTIL   = 1'b1;
        B_BUS_IN = 1'($urandom);
        tick();
        B_SEL = 1'b1;
        stop  = 1'b1;
      end else begin
        if (i == gap_at && gap > 0) begin
          B_UTIL   = 1'b0;
          B_BUS_IN = 1'($urandom);
          repeat (gap < TO ? gap : TO) tick();
          stop = (gap >= TO);
        end
        if (!stop) begin
          B_UTIL = 1'b1;
          if (i < 16) B_BUS_IN = frame[i];
          else        B_BUS_IN = wd[i-16];
          tick();
          if (i == 15) begin
            chk("e0_ack", 32'(B_ACK), 32'(rw));
            chk("e0_ready", 32'(B_READY), 32'd0);
            chk("e0_ren", 32'(S_REN), 32'(!rw));
            chk("e0_addr", 32'(S_ADDR), 32'(ea));
          end
        end
      end
    end
    B_UTIL = 1'b0;
    if (rw && !abort_a && !abort_d) begin
      chk("w_wen", 32'({S_WEN, B_ACK}), 32'b10);
      tick();
      chk("w_ack2", 32'({B_ACK, S_WEN, B_READY}), 32'b100);
      tick();
      chk("w_ready", 32'({B_READY, B_ACK}), 32'b10);
    end
    if (!rw && !abort_a && !tout) begin
      n = 0;
      while (!B_RVALID && n < 40) begin tick(); n++; end
      chk("rd_latency", 32'(n), 32'(lat + 2));
      n = 0;
      while (B_RVALID && n < 20) begin tick(); n++; end
      chk("rd_len", 32'(n), 32'd8);
    end
    n = 0;
    while (!B_READY && n < 100) begin tick(); n++; end
    chk("ready_back", 32'(B_READY), 32'd1);
    if (tout) chk("rd_timeout_cycles", 32'(n), 32'(TO));
    repeat (2) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] fr;
    logic        rw;
    logic [7:0]  wd, rd;
    int          lat, gap, gat, dat, r, n;
    RST = 1'b1; B_SEL = 1'b1; B_UTIL = 1'b0;
    B_BUS_IN = 1'b0; B_RW = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_outs", 32'({B_READY, B_ACK, B_BUS_OUT, B_RVALID,
                           S_WEN, S_REN}), 32'd0);
      chk("rst_data", 32'({S_ADDR, S_WDATA}), 32'd0);
    end
    RST = 1'b0;
    tick();
    chk("ready_after_rst", 32'(B_READY), 32'd1);

    do_txn(16'hA5C6, 1'b1, 8'h3C, 8'h00, 1, 0, 0, -1);
    do_txn(16'hA5C6, 1'b0, 8'h00, 8'hB2, 4, 0, 0, -1);
    for (int g = 1; g < TO; g++)
      do_txn(16'hA5C6, 1'b1, 8'h3C, 8'h00, 1, g, (g % 23) + 1, -1);
    do_txn(16'hA5C6, 1'b1, 8'h3C, 8'h00, 1, TO, 5, -1);
    do_txn(16'hA5C6, 1'b1, 8'h3C, 8'h00, 1, TO, 18, -1);
    do_txn(16'h1234, 1'b0, 8'h00, 8'h77, -1, 0, 0, -1);
    do_txn(16'hA5C6, 1'b1, 8'h3C, 8'h00, 1, 0, 0, 8);

    // reset during read bit 3
    ren_q.push_back(AW'(16'h5EED >> 2));
    ack_q.push_back(3);
    for (int i = 0; i < 8; i++) bit_q.push_back(r_pat(i));
    resp_lat = 1; resp_data = 8'hA6; B_RW = 1'b0;
    fr = 16'h5EED;
    for (int i = 0; i < 16; i++) begin
      B_UTIL = 1'b1; B_BUS_IN = fr[i]; tick();
    end
    B_UTIL = 1'b0;
    n = 0;
    while (!B_RVALID && n < 40) begin tick(); n++; end
    chk("rr_bit0_seen", 32'(B_RVALID), 32'd1);
    repeat (3) tick();
    RST = 1'b1;
    tick();
    chk("rr_outs", 32'({B_RVALID, B_BUS_OUT, B_READY}), 32'd0);
    chk("rr_bits_left", 32'(bit_q.size()), 32'd4);
    bit_q.delete();
    RST = 1'b0;
    tick();
    chk("rr_ready", 32'(B_READY), 32'd1);
    do_txn(16'hC3A9, 1'b1, 8'h96, 8'h00, 1, 0, 0, -1);

    for (int t = 0; t < 40; t++) begin
      fr  = 16'($urandom);
      rw  = 1'($urandom);
      wd  = 8'($urandom);
      rd  = 8'($urandom);
      lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, TO - 2));
      r   = int'($urandom_range(0, 9));
      gap = (r < 4) ? 0 : (r == 9) ? TO : int'($urandom_range(1, TO - 1));
      gat = int'($urandom_range(1, rw ? 23 : 15));
      dat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 15)) : -1;
      do_txn(fr, rw, wd, rd, lat, gap, gat, dat);
    end

    repeat (4) tick();
    chk("wen_q_empty", 32'(wen_q.size()), 32'd0);
    chk("ren_q_empty", 32'(ren_q.size()), 32'd0);
    chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
    chk("bit_q_empty", 32'(bit_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  function automatic logic r_pat(input int i);
    logic [7:0] v;
    v = 8'hA6;
    return v[i];
  endfunction

endmodule
